// File: rtl/inst_pkg.sv
// Shared decode definitions: internal op codes, RV32I opcode/funct fields,
// the decoded-field record and 32-bit instruction encoders used by the RVC expander.
package inst_pkg;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_AND     = 5'd2;
  localparam logic [4:0] OP_OR      = 5'd3;
  localparam logic [4:0] OP_XOR     = 5'd4;
  localparam logic [4:0] OP_SLL     = 5'd5;
  localparam logic [4:0] OP_SRL     = 5'd6;
  localparam logic [4:0] OP_SRA     = 5'd7;
  localparam logic [4:0] OP_SLT     = 5'd8;
  localparam logic [4:0] OP_SLTU    = 5'd9;
  localparam logic [4:0] OP_LUI     = 5'd10;
  localparam logic [4:0] OP_AUIPC   = 5'd11;
  localparam logic [4:0] OP_JAL     = 5'd12;
  localparam logic [4:0] OP_JALR    = 5'd13;
  localparam logic [4:0] OP_BEQ     = 5'd14;
  localparam logic [4:0] OP_BNE     = 5'd15;
  localparam logic [4:0] OP_BLT     = 5'd16;
  localparam logic [4:0] OP_BGE     = 5'd17;
  localparam logic [4:0] OP_BLTU    = 5'd18;
  localparam logic [4:0] OP_BGEU    = 5'd19;
  localparam logic [4:0] OP_LB      = 5'd20;
  localparam logic [4:0] OP_LH      = 5'd21;
  localparam logic [4:0] OP_LW      = 5'd22;
  localparam logic [4:0] OP_LBU     = 5'd23;
  localparam logic [4:0] OP_LHU     = 5'd24;
  localparam logic [4:0] OP_SB      = 5'd25;
  localparam logic [4:0] OP_SH      = 5'd26;
  localparam logic [4:0] OP_SW      = 5'd27;
  localparam logic [4:0] OP_INVALID = 5'd31;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  op;
    logic        branch;
    logic        ls;
    logic        use_imm;
    logic        jalr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_t;

  localparam dec_t DEC_INVALID = '{op: OP_INVALID, branch: 1'b0, ls: 1'b0,
                                   use_imm: 1'b0, jalr: 1'b0, rd: 5'd0,
                                   rs1: 5'd0, rs2: 5'd0, imm: 32'd0};

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/rv_inst_decoder_if.sv
// Fetch-side bundle between the instruction cache path and the decoder:
// instruction request in, registered decode fields out.
interface rv_inst_decoder_if;

  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic        inst_length;
  logic        out_valid;
  logic [4:0]  op;
  logic        branch;
  logic        ls;
  logic        use_imm;
  logic        jalr;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output flush, in_valid, inst, inst_length,
    input  out_valid, op, branch, ls, use_imm, jalr, rd, rs1, rs2, imm
  );

  modport slave (
    input  flush, in_valid, inst, inst_length,
    output out_valid, op, branch, ls, use_imm, jalr, rd, rs1, rs2, imm
  );

endinterface

// File: rtl/rvc_expander.sv
// Combinational RV32C -> RV32I expander. Reserved/unsupported halfwords
// (including all-zero) raise illegal; the 32-bit word is then meaningless.
module rvc_expander
  import inst_pkg::*;
(
  input  logic [15:0] inst16,
  output logic [31:0] inst32,
  output logic        illegal
);

  logic [4:0]  rd_s, rs2_s, rdp_s, rs1p_s;
  logic [11:0] imm6_s, cj_s;
  logic [8:0]  cb_s;
  logic [9:0]  nzuimm_s, nzimm16_s;
  logic [6:0]  uimm_w_s;
  logic [7:0]  uimm_lwsp_s, uimm_swsp_s;

  // Primed 3-bit register fields address x8..x15
  assign rd_s        = inst16[11:7];
  assign rs2_s       = inst16[6:2];
  assign rdp_s       = {2'b01, inst16[4:2]};
  assign rs1p_s      = {2'b01, inst16[9:7]};
  assign imm6_s      = {{6{inst16[12]}}, inst16[12], inst16[6:2]};
  assign cj_s        = {inst16[12], inst16[8], inst16[10:9], inst16[6], inst16[7],
                        inst16[2], inst16[11], inst16[5:3], 1'b0};
  assign cb_s        = {inst16[12], inst16[6:5], inst16[2], inst16[11:10], inst16[4:3], 1'b0};
  assign nzuimm_s    = {inst16[10:7], inst16[12:11], inst16[5], inst16[6], 2'b00};
  assign nzimm16_s   = {inst16[12], inst16[4:3], inst16[5], inst16[2], inst16[6], 4'b0000};
  assign uimm_w_s    = {inst16[5], inst16[12:10], inst16[6], 2'b00};
  assign uimm_lwsp_s = {inst16[3:2], inst16[12], inst16[6:4], 2'b00};
  assign uimm_swsp_s = {inst16[8:7], inst16[12:9], 2'b00};

  // Quadrant / funct3 expansion table
  always_comb begin
    inst32  = 32'h0000_0000;
    illegal = 1'b0;
    case (inst16[1:0])
      2'b00: begin
        case (inst16[15:13])
          3'b000: begin
            inst32  = enc_i({2'b00, nzuimm_s}, 5'd2, F3_ADD, rdp_s, OPC_OP_IMM);
            illegal = (nzuimm_s == 10'd0);
          end
          3'b010:  inst32 = enc_i({5'd0, uimm_w_s}, rs1p_s, F3_W, rdp_s, OPC_LOAD);
          3'b110:  inst32 = enc_s({5'd0, uimm_w_s}, rdp_s, rs1p_s, F3_W);
          default: illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (inst16[15:13])
          3'b000: inst32 = enc_i(imm6_s, rd_s, F3_ADD, rd_s, OPC_OP_IMM);
          3'b001: inst32 = enc_j({{9{cj_s[11]}}, cj_s}, 5'd1);
          3'b010: inst32 = enc_i(imm6_s, 5'd0, F3_ADD, rd_s, OPC_OP_IMM);
          3'b011: begin
            if (rd_s == 5'd2) begin
              inst32  = enc_i({{2{nzimm16_s[9]}}, nzimm16_s}, 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
              illegal = (nzimm16_s == 10'd0);
            end else begin
              inst32  = {{14{inst16[12]}}, inst16[12], inst16[6:2], rd_s, OPC_LUI};
              illegal = ({inst16[12], inst16[6:2]} == 6'd0);
            end
          end
          3'b100: begin
            case (inst16[11:10])
              2'b00: begin
                inst32  = enc_i({F7_BASE, inst16[6:2]}, rs1p_s, F3_SR, rs1p_s, OPC_OP_IMM);
                illegal = inst16[12];
              end
              2'b01: begin
                inst32  = enc_i({F7_ALT, inst16[6:2]}, rs1p_s, F3_SR, rs1p_s, OPC_OP_IMM);
                illegal = inst16[12];
              end
              2'b10: inst32 = enc_i(imm6_s, rs1p_s, F3_AND, rs1p_s, OPC_OP_IMM);
              default: begin
                illegal = inst16[12];
                case (inst16[6:5])
                  2'b00:   inst32 = enc_r(F7_ALT, rdp_s, rs1p_s, F3_ADD, rs1p_s);
                  2'b01:   inst32 = enc_r(F7_BASE, rdp_s, rs1p_s, F3_XOR, rs1p_s);
                  2'b10:   inst32 = enc_r(F7_BASE, rdp_s, rs1p_s, F3_OR, rs1p_s);
                  default: inst32 = enc_r(F7_BASE, rdp_s, rs1p_s, F3_AND, rs1p_s);
                endcase
              end
            endcase
          end
          3'b101:  inst32 = enc_j({{9{cj_s[11]}}, cj_s}, 5'd0);
          3'b110:  inst32 = enc_b({{4{cb_s[8]}}, cb_s}, 5'd0, rs1p_s, F3_BEQ);
          default: inst32 = enc_b({{4{cb_s[8]}}, cb_s}, 5'd0, rs1p_s, F3_BNE);
        endcase
      end
      2'b10: begin
        case (inst16[15:13])
          3'b000: begin
            inst32  = enc_i({F7_BASE, inst16[6:2]}, rd_s, F3_SLL, rd_s, OPC_OP_IMM);
            illegal = inst16[12];
          end
          3'b010: begin
            inst32  = enc_i({4'd0, uimm_lwsp_s}, 5'd2, F3_W, rd_s, OPC_LOAD);
            illegal = (rd_s == 5'd0);
          end
          3'b100: begin
            // rs2 == 0 selects the jump forms; rd == 0 there is reserved / EBREAK
            if (rs2_s == 5'd0) begin
              inst32  = enc_i(12'h000, rd_s, F3_ADD, {4'd0, inst16[12]}, OPC_JALR);
              illegal = (rd_s == 5'd0);
            end else begin
              inst32  = enc_r(F7_BASE, rs2_s, inst16[12] ? rd_s : 5'd0, F3_ADD, rd_s);
              illegal = 1'b0;
            end
          end
          3'b110:  inst32 = enc_s({4'd0, uimm_swsp_s}, rs2_s, 5'd2, F3_W);
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_inst_decoder.sv
// Registered RV32I/RV32C decoder for the fetch stage. Compressed decode is
// compiled in only when the RVC_EN macro is defined.
module rv_inst_decoder
  import inst_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  rv_inst_decoder_if.slave bus
);

  // Fields are filled speculatively per format; an unsupported encoding wipes them
  function automatic dec_t decode32(input logic [31:0] w);
    dec_t       d;
    logic [4:0] sel;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = w[14:12];
    f7  = w[31:25];
    sel = OP_INVALID;
    d   = DEC_INVALID;
    case (w[6:0])
      OPC_LUI, OPC_AUIPC: begin
        sel       = (w[6:0] == OPC_LUI) ? OP_LUI : OP_AUIPC;
        d.use_imm = 1'b1;
        d.rd      = w[11:7];
        d.imm     = {w[31:12], 12'h000};
      end
      OPC_JAL: begin
        sel       = OP_JAL;
        d.use_imm = 1'b1;
        d.rd      = w[11:7];
        d.imm     = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      OPC_JALR: begin
        sel       = (f3 == F3_ADD) ? OP_JALR : OP_INVALID;
        d.jalr    = 1'b1;
        d.use_imm = 1'b1;
        d.rd      = w[11:7];
        d.rs1     = w[19:15];
        d.imm     = {{20{w[31]}}, w[31:20]};
      end
      OPC_BRANCH: begin
        case (f3)
          F3_BEQ:  sel = OP_BEQ;
          F3_BNE:  sel = OP_BNE;
          F3_BLT:  sel = OP_BLT;
          F3_BGE:  sel = OP_BGE;
          F3_BLTU: sel = OP_BLTU;
          F3_BGEU: sel = OP_BGEU;
          default: sel = OP_INVALID;
        endcase
        d.branch = 1'b1;
        d.rs1    = w[19:15];
        d.rs2    = w[24:20];
        d.imm    = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      OPC_LOAD: begin
        case (f3)
          F3_B:    sel = OP_LB;
          F3_H:    sel = OP_LH;
          F3_W:    sel = OP_LW;
          F3_BU:   sel = OP_LBU;
          F3_HU:   sel = OP_LHU;
          default: sel = OP_INVALID;
        endcase
        d.ls      = 1'b1;
        d.use_imm = 1'b1;
        d.rd      = w[11:7];
        d.rs1     = w[19:15];
        d.imm     = {{20{w[31]}}, w[31:20]};
      end
      OPC_STORE: begin
        case (f3)
          F3_B:    sel = OP_SB;
          F3_H:    sel = OP_SH;
          F3_W:    sel = OP_SW;
          default: sel = OP_INVALID;
        endcase
        d.ls      = 1'b1;
        d.use_imm = 1'b1;
        d.rs1     = w[19:15];
        d.rs2     = w[24:20];
        d.imm     = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      OPC_OP_IMM: begin
        case (f3)
          F3_ADD:  sel = OP_ADD;
          F3_SLT:  sel = OP_SLT;
          F3_SLTU: sel = OP_SLTU;
          F3_XOR:  sel = OP_XOR;
          F3_OR:   sel = OP_OR;
          F3_AND:  sel = OP_AND;
          F3_SLL:  sel = (f7 == F7_BASE) ? OP_SLL : OP_INVALID;
          default: sel = (f7 == F7_BASE) ? OP_SRL : ((f7 == F7_ALT) ? OP_SRA : OP_INVALID);
        endcase
        d.use_imm = 1'b1;
        d.rd      = w[11:7];
        d.rs1     = w[19:15];
        d.imm     = (f3 == F3_SLL || f3 == F3_SR) ? {27'd0, w[24:20]}
                                                  : {{20{w[31]}}, w[31:20]};
      end
      OPC_OP: begin
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  sel = OP_ADD;
          {F7_ALT,  F3_ADD}:  sel = OP_SUB;
          {F7_BASE, F3_SLL}:  sel = OP_SLL;
          {F7_BASE, F3_SLT}:  sel = OP_SLT;
          {F7_BASE, F3_SLTU}: sel = OP_SLTU;
          {F7_BASE, F3_XOR}:  sel = OP_XOR;
          {F7_BASE, F3_SR}:   sel = OP_SRL;
          {F7_ALT,  F3_SR}:   sel = OP_SRA;
          {F7_BASE, F3_OR}:   sel = OP_OR;
          {F7_BASE, F3_AND}:  sel = OP_AND;
          default:            sel = OP_INVALID;
        endcase
        d.rd  = w[11:7];
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
      end
      default: sel = OP_INVALID;
    endcase
    if (sel == OP_INVALID) begin
      d = DEC_INVALID;
    end else begin
      d.op = sel;
    end
    return d;
  endfunction

  logic [31:0] word_s;
  logic        illegal_s;
  dec_t        dec_s;
  dec_t        dec_r;
  logic        valid_r;

`ifdef RVC_EN
  logic [31:0] exp_word_s;
  logic        exp_illegal_s;

  rvc_expander u_rvc_expander (
    .inst16  (bus.inst[15:0]),
    .inst32  (exp_word_s),
    .illegal (exp_illegal_s)
  );

  // Select the native word or the expanded compressed word
  always_comb begin
    if (bus.inst_length) begin
      word_s    = bus.inst;
      illegal_s = 1'b0;
    end else begin
      word_s    = exp_word_s;
      illegal_s = exp_illegal_s;
    end
  end
`else
  // Without compressed support every 16-bit input is illegal
  always_comb begin
    word_s    = bus.inst;
    illegal_s = ~bus.inst_length;
  end
`endif

  // Combinational decode of the selected word
  always_comb begin
    if (illegal_s) begin
      dec_s = DEC_INVALID;
    end else begin
      dec_s = decode32(word_s);
    end
  end

  // Output stage: hold on !rdy_in, flush beats load, fields load only with in_valid
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_r <= 1'b0;
      dec_r   <= DEC_INVALID;
    end else if (rdy_in) begin
      if (bus.flush) begin
        valid_r <= 1'b0;
        dec_r   <= DEC_INVALID;
      end else begin
        valid_r <= bus.in_valid;
        if (bus.in_valid) begin
          dec_r <= dec_s;
        end
      end
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.op        = dec_r.op;
  assign bus.branch    = dec_r.branch;
  assign bus.ls        = dec_r.ls;
  assign bus.use_imm   = dec_r.use_imm;
  assign bus.jalr      = dec_r.jalr;
  assign bus.rd        = dec_r.rd;
  assign bus.rs1       = dec_r.rs1;
  assign bus.rs2       = dec_r.rs2;
  assign bus.imm       = dec_r.imm;

endmodule

// File: tb/tb_rv_inst_decoder.sv
// Directed self-checking bench for rv_inst_decoder; expectations are hand-decoded
// encodings. Compressed expectations follow the RVC_EN macro.
module tb_rv_inst_decoder;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   n_tests = 0;
  int   n_fail  = 0;

  rv_inst_decoder_if bus ();

  rv_inst_decoder dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_dec(input string tag, input logic v, input logic [4:0] op,
                            input logic br, input logic ls, input logic ui, input logic jl,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    check_eq({tag, ".valid"},   {31'd0, bus.out_valid}, {31'd0, v});
    check_eq({tag, ".op"},      {27'd0, bus.op},        {27'd0, op});
    check_eq({tag, ".branch"},  {31'd0, bus.branch},    {31'd0, br});
    check_eq({tag, ".ls"},      {31'd0, bus.ls},        {31'd0, ls});
    check_eq({tag, ".use_imm"}, {31'd0, bus.use_imm},   {31'd0, ui});
    check_eq({tag, ".jalr"},    {31'd0, bus.jalr},      {31'd0, jl});
    check_eq({tag, ".rd"},      {27'd0, bus.rd},        {27'd0, rd});
    check_eq({tag, ".rs1"},     {27'd0, bus.rs1},       {27'd0, rs1});
    check_eq({tag, ".rs2"},     {27'd0, bus.rs2},       {27'd0, rs2});
    check_eq({tag, ".imm"},     bus.imm,                imm);
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic len);
    @(negedge clk_in);
    bus.in_valid    = v;
    bus.inst        = w;
    bus.inst_length = len;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in          = 1'b0;
    rdy_in          = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.inst        = 32'h0000_0000;
    bus.inst_length = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    expect_dec("reset", 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;

    step(1'b1, 32'h0050_0093, 1'b1);
    expect_dec("addi",  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step(1'b1, 32'hFE20_8CE3, 1'b1);
    expect_dec("beq",   1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    step(1'b1, 32'h0000_8067, 1'b1);
    expect_dec("jalr",  1'b1, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 32'h0);
    step(1'b1, 32'h0021_A423, 1'b1);
    expect_dec("sw",    1'b1, 5'd27, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 5'd2, 32'd8);
    step(1'b1, 32'h4020_81B3, 1'b1);
    expect_dec("sub",   1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
    step(1'b1, 32'h4033_5293, 1'b1);
    expect_dec("srai",  1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 32'd3);
    step(1'b1, 32'h1234_53B7, 1'b1);
    expect_dec("lui",   1'b1, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000);
    step(1'b1, 32'hFFDF_F0EF, 1'b1);
    expect_dec("jal",   1'b1, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC);
    step(1'b1, 32'hFFF2_C203, 1'b1);
    expect_dec("lbu",   1'b1, 5'd23, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 32'h0000_0000, 1'b1);
    expect_dec("zero",  1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    step(1'b1, 32'h0000_0073, 1'b1);
    expect_dec("ecall", 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    step(1'b1, 32'h0220_81B3, 1'b1);
    expect_dec("mul",   1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

`ifdef RVC_EN
    step(1'b1, 32'h0000_4505, 1'b0);
    expect_dec("c.li",  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 32'd1);
    step(1'b1, 32'h0000_852E, 1'b0);
    expect_dec("c.mv",  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd11, 32'h0);
    step(1'b1, 32'h0000_8082, 1'b0);
    expect_dec("c.jr",  1'b1, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 32'h0);
    step(1'b1, 32'h0000_4144, 1'b0);
    expect_dec("c.lw",  1'b1, 5'd22, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 5'd10, 5'd0, 32'd4);
    step(1'b1, 32'h0000_0000, 1'b0);
    expect_dec("c.zero", 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
`else
    step(1'b1, 32'h0000_4505, 1'b0);
    expect_dec("c.li",  1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    step(1'b1, 32'h0000_852E, 1'b0);
    expect_dec("c.mv",  1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
`endif

    // Enable low: the sub result must survive three edges of fresh input
    step(1'b1, 32'h4020_81B3, 1'b1);
    @(negedge clk_in);
    rdy_in       = 1'b0;
    bus.inst     = 32'h0050_0093;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      expect_dec("hold", 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
    end

    @(negedge clk_in);
    rdy_in    = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk_in);
    #1;
    expect_dec("flush", 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk_in);
    bus.flush = 1'b0;

    step(1'b1, 32'h0050_0093, 1'b1);
    expect_dec("reload", 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step(1'b0, 32'h1234_53B7, 1'b1);
    expect_dec("idle",   1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);

    // Reset in the middle of the high phase, checked before any further edge
    step(1'b1, 32'h4020_81B3, 1'b1);
    #2;
    rst_in = 1'b0;
    #1;
    expect_dec("async_rst", 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_inst_decoder.md
# rv_inst_decoder

Registered RV32I/RV32C instruction decoder in the fetch stage. It takes the instruction word and length from the instruction cache path. It produces the internal 5-bit op code, register indices, sign-extended immediate and class flags consumed by the fetch controller and the issue queue. Decode is combinational, followed by a single output register stage.

## Interface
Parameters:
- none; op encodings come from the shared package.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  reset, asynchronous and active-low.
- rdy_in  in  1  global enable; low holds all outputs.
- flush  in  1  misprediction flush; clears out_valid.
- in_valid  in  1  inst/inst_length hold a fetched instruction.
- inst  in  32  instruction; for 16-bit instructions only [15:0] is used.
- inst_length  in  1  1 = 32-bit instruction, 0 = 16-bit compressed.
- out_valid  out  1  decoded fields valid.
- op  out  5  operation code.
- branch  out  1  conditional branch (BEQ..BGEU).
- ls  out  1  load or store.
- use_imm  out  1  second operand is imm.
- rd, rs1, rs2  out  5 each  register indices; 0 when the field is unused.
- imm  out  32  sign-extended immediate.
- jalr  out  1  instruction is JALR (including C.JR and C.JALR).

## Operation
- Op codes:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9
  - LUI 10, AUIPC 11, JAL 12, JALR 13
  - BEQ 14, BNE 15, BLT 16, BGE 17, BLTU 18, BGEU 19
  - LB 20, LH 21, LW 22, LBU 23, LHU 24, SB 25, SH 26, SW 27
  - INVALID 31
- I-type ALU instructions (ADDI etc.) map to the same op as their R-type form, with use_imm=1. There is no SUBI.
- use_imm=1 for: I-type ALU, loads, stores, LUI, AUIPC, JAL, JALR. use_imm=0 for R-type and conditional branches.
- imm by format:
  - I/S: sign-extended 12-bit.
  - B: sign-extended 13-bit byte offset (bit 0 = 0).
  - J: sign-extended 21-bit byte offset.
  - LUI/AUIPC: inst[31:12]<<12.
  - Shift-immediates: shamt zero-extended.
  - R-type: 0.
- Unused fields are forced to 0: rd for stores and branches; rs1 for LUI/AUIPC/JAL; rs2 for everything other than R, S and B formats.
- Any unsupported opcode, funct3 or funct7 (including FENCE, ECALL, CSR) gives op=INVALID with all other outputs 0.
- Compressed instructions are expanded to their standard RV32I equivalents per the RVC spec. rd/rs use the full 5-bit index; 3-bit fields map to x8–x15.
  - C.J gives JAL with rd=0; C.JAL gives JAL with rd=1.
  - C.JR gives JALR with rd=0; C.JALR gives JALR with rd=1.
  - C.MV gives ADD with rs1=0.
  - Reserved encodings and all-zero halfwords give INVALID.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Reset (asynchronous, rst_in=0): out_valid=0, op=INVALID, every other output 0.
- rdy_in=0: all registers hold, including out_valid.
- Priority, with rdy_in=1: flush first (out_valid←0 and fields←reset values, in_valid ignored that cycle), then normal load.
- Normal load: out_valid←in_valid. Fields update only when in_valid=1; otherwise they hold.
- Reset asserted mid-operation clears the output stage immediately, with no clock edge required.

## Configuration
- RVC_EN defined: compressed decode is compiled in.
- RVC_EN undefined: any input with inst_length=0 decodes to INVALID, and the expander logic is absent.

## Structure
- Shared package inst_pkg: op code localparams, RV32I opcode/funct3 constants.
- One sub-module rvc_expander: combinational 16→32-bit expansion with an illegal flag. It is instantiated only under RVC_EN.

## Test plan
- 0x00500093 (addi x1,x0,5), in_valid=1 → one cycle later: out_valid=1, op=ADD, use_imm=1, rd=1, rs1=0, rs2=0, imm=5.
- 0xFE208CE3 (beq x1,x2,-8) → op=BEQ, branch=1, rs1=1, rs2=2, rd=0, imm=0xFFFFFFF8, use_imm=0.
- 0x00008067 (jalr x0,0(x1)) → op=JALR, jalr=1, rs1=1, rd=0, imm=0. Then 0x0021A423 (sw x2,8(x3)) → op=SW, ls=1, rs1=3, rs2=2, imm=8.
- 0x4505 with inst_length=0 → RVC_EN defined: op=ADD, use_imm=1, rd=10, rs1=0, imm=1. RVC_EN undefined: op=INVALID.
- 0x00000000 (32-bit) → op=INVALID, all fields 0, out_valid=1.
- Sequencing checks:
  - Valid decode, then rdy_in=0 for 3 cycles → outputs unchanged.
  - flush together with in_valid → out_valid=0 next cycle.
  - rst_in low mid-cycle → out_valid=0 immediately.
